highscore_ctrl: RTL and testbench
=================================

// Module: highscore_ctrl
// PURPOSE
//   Sequences one game round and the high-score compare datapath.
//   Counts the current score during play; on game over, runs it through score_compare against the stored high score.
//   Commits a new record, holds the result for display, then returns to idle.
//   Sits between game-logic pulses (start/point/game_over) and the score display driver.
// PARAMETERS
//   SCORE_W     8    width of current_score and high_score
//   PT_STEP     1    amount added per point_inc pulse
//   HOLD_CYCLES 50   cycles spent in SHOW before returning to IDLE (>=1)
// PORTS
//   clk            in   1        system clock, rising edge
//   rst_n          in   1        asynchronous, active-low reset
//   start          in   1        begin a round (honoured in IDLE only)
//   point_inc      in   1        one-cycle pulse: add PT_STEP (honoured in PLAY only)
//   game_over      in   1        end round (honoured in PLAY only)
//   clear_hs       in   1        zero the high score (honoured in IDLE only)
//   current_score  out  SCORE_W  running score of this/last round
//   high_score     out  SCORE_W  stored best score
//   new_record     out  1        high while SHOW follows a strict improvement
//   busy           out  1        high in every state except IDLE
//   done           out  1        one-cycle pulse on the SHOW->IDLE edge
//   state_o        out  3        current FSM state (debug/display)
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; hold counter 0; high score lost (no retention).
//   Reset during any state aborts the round immediately.
//   States (3-bit): IDLE=0, PLAY=1, CMP=2, UPD=3, SHOW=4; other codes -> IDLE.
//   IDLE:
//     - clear_hs=1 -> high_score<=0.
//     - start=1 -> current_score<=0, new_record<=0, goto PLAY.
//     - start and clear_hs together: both take effect.
//   PLAY:
//     - point_inc adds PT_STEP, saturating at 2^SCORE_W-1; never wraps.
//     - game_over -> CMP.
//     - point_inc and game_over in the same cycle: the point counts.
//       CMP then sees the incremented score.
//     - start and clear_hs are ignored.
//   CMP: drives score_compare with (high_score, current_score); registers its max and gt flag; goto UPD.
//   UPD: if gt (current > high, strict), high_score<=current_score and new_record<=1; else no change; goto SHOW.
//   SHOW: hold counter runs 0..HOLD_CYCLES-1, then goto IDLE with done=1 for that one cycle.
//     - new_record stays asserted until the next start.
//   Latency: game_over sampled at edge E0 -> high_score/new_record update at edge E2 -> done at edge E2+HOLD_CYCLES.
//   Inputs outside their honouring state are ignored; no queuing.
//   Tie (current == high) is not a record.
//   current_score holds its value after the round until the next start.
// STRUCTURE
//   hs_pkg: state encodings, SCORE_W default, saturating-add function.
//   Sub-module score_compare: combinational; inputs a, b; outputs max, a_gt_b. Instantiated once.
//   highscore_ctrl owns the FSM, score counter, hold counter and result registers.
// TESTING
//   1 Assert rst_n=0 mid-stream -> all outputs 0, state_o=0; release -> stays IDLE.
//   2 high=0; start, 5 point_inc, game_over:
//     - high_score=5 at E2; new_record=1.
//     - done pulses HOLD_CYCLES later; busy falls with done.
//   3 high=5:
//     - round of 3 -> high_score=5, new_record=0.
//     - round of 5 (tie) -> high_score=5, new_record=0.
//   4 SCORE_W=8: 300 point_inc pulses -> current_score=255; game_over -> high_score=255.
//   5 score 9; point_inc and game_over same cycle -> CMP sees 10; high_score=10.
//   6 clear_hs during PLAY -> ignored.
//     clear_hs in IDLE -> high_score=0.
//     rst_n low during SHOW -> no done pulse; outputs 0.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared state encodings, default score width and the saturating adder for the
// high-score controller.
package hs_pkg;

  localparam int SCORE_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_CMP  = 3'd2,
    S_UPD  = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Unsigned add that clamps at lim instead of wrapping.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] step,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, step};
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

endpackage

// File: rtl/score_compare.sv
// Combinational compare of two scores: larger value and strict a > b flag.
module score_compare #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] max,
  output logic         a_gt_b
);

  always_comb begin
    a_gt_b = (a > b);
    max    = a_gt_b ? a : b;
  end

endmodule

// File: rtl/highscore_ctrl.sv
// Game-round sequencer: counts the score during play, compares it against the
// stored high score on game over, commits a record and holds the result.
//
//   state | meaning
//   IDLE  | waiting for start; clear_hs zeroes the high score
//   PLAY  | counting point_inc pulses until game_over
//   CMP   | latch compare result of current vs high score
//   UPD   | commit record if strictly better
//   SHOW  | hold result for HOLD_CYCLES, then pulse done
module highscore_ctrl
  import hs_pkg::*;
#(
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int PT_STEP     = 1,
  parameter int HOLD_CYCLES = 50
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               point_inc,
  input  logic               game_over,
  input  logic               clear_hs,
  output logic [SCORE_W-1:0] current_score,
  output logic [SCORE_W-1:0] high_score,
  output logic               new_record,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_o
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t             state, state_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               hold_last;
  logic [SCORE_W-1:0] cmp_max, max_q;
  logic               cmp_gt, gt_q;

  assign hold_last = (hold_cnt == HOLD_LAST);

  // a = current, b = high so that a_gt_b is the strict-improvement flag.
  score_compare #(.W(SCORE_W)) u_cmp (
    .a      (current_score),
    .b      (high_score),
    .max    (cmp_max),
    .a_gt_b (cmp_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = start ? S_PLAY : S_IDLE;
      S_PLAY:  state_nxt = game_over ? S_CMP : S_PLAY;
      S_CMP:   state_nxt = S_UPD;
      S_UPD:   state_nxt = S_SHOW;
      S_SHOW:  state_nxt = hold_last ? S_IDLE : S_SHOW;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    state_o = state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      current_score <= '0;
      high_score    <= '0;
      new_record    <= 1'b0;
      done          <= 1'b0;
      hold_cnt      <= '0;
      max_q         <= '0;
      gt_q          <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear_hs) high_score <= '0;
          if (start) begin
            current_score <= '0;
            new_record    <= 1'b0;
          end
        end
        S_PLAY: begin
          if (point_inc)
            current_score <= SCORE_W'(sat_add(32'(current_score), 32'(PT_STEP),
                                              32'(SCORE_MAX)));
        end
        S_CMP: begin
          max_q <= cmp_max;
          gt_q  <= cmp_gt;
        end
        S_UPD: begin
          if (gt_q) begin
            high_score <= max_q;
            new_record <= 1'b1;
          end
        end
        S_SHOW: begin
          if (hold_last) begin
            hold_cnt <= '0;
            done     <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_highscore_ctrl.sv
// Self-checking bench for highscore_ctrl: randomized rounds compared against a
// plain arithmetic model of score, high score and record flag.
module tb_highscore_ctrl;

  localparam int SCORE_W = 8;
  localparam int STEP    = 1;
  localparam int HOLD    = 50;
  localparam int MAXV    = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               point_inc = 1'b0;
  logic               game_over = 1'b0;
  logic               clear_hs = 1'b0;
  logic [SCORE_W-1:0] current_score;
  logic [SCORE_W-1:0] high_score;
  logic               new_record;
  logic               busy;
  logic               done;
  logic [2:0]         state_o;

  int errors = 0;
  int checks = 0;
  int m_high = 0;
  int m_cur  = 0;
  bit m_rec  = 1'b0;

  highscore_ctrl #(.SCORE_W(SCORE_W), .PT_STEP(STEP), .HOLD_CYCLES(HOLD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .point_inc     (point_inc),
    .game_over     (game_over),
    .clear_hs      (clear_hs),
    .current_score (current_score),
    .high_score    (high_score),
    .new_record    (new_record),
    .busy          (busy),
    .done          (done),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full round: start, n points (optionally last one merged with
  // game_over), then compare/update/show timing and values.
  task automatic do_round(input int n, input bit merge, input bit noise, input bit clr_start);
    int old_high;
    int cnt;
    start = 1'b1;
    clear_hs = clr_start;
    tick();
    start = 1'b0;
    clear_hs = 1'b0;
    if (clr_start) m_high = 0;
    m_cur = 0;
    m_rec = 1'b0;
    checks++; if (state_o !== 3'd1) begin errors++; $display("FAIL start_state: got %0d want 1", state_o); end
    checks++; if (current_score !== SCORE_W'(0)) begin errors++; $display("FAIL start_score: got %0d want 0", current_score); end
    checks++; if (high_score !== SCORE_W'(m_high)) begin errors++; $display("FAIL start_high: got %0d want %0d", high_score, m_high); end
    checks++; if (new_record !== 1'b0) begin errors++; $display("FAIL start_rec: got %0b want 0", new_record); end
    for (int i = 0; i < n; i++) begin
      if (noise) begin
        repeat ($urandom_range(0, 2)) begin
          start    = 1'($urandom_range(0, 1));
          clear_hs = 1'($urandom_range(0, 1));
          tick();
        end
        start = 1'b0;
        clear_hs = 1'b0;
      end
      point_inc = 1'b1;
      if (merge && i == n - 1) game_over = 1'b1;
      tick();
      point_inc = 1'b0;
      m_cur = (m_cur + STEP > MAXV) ? MAXV : m_cur + STEP;
    end
    if (!(merge && n > 0)) begin
      game_over = 1'b1;
      tick();
    end
    game_over = 1'b0;
    checks++; if (state_o !== 3'd2) begin errors++; $display("FAIL cmp_state: got %0d want 2", state_o); end
    checks++; if (current_score !== SCORE_W'(m_cur)) begin errors++; $display("FAIL round_score: got %0d want %0d", current_score, m_cur); end
    old_high = m_high;
    if (m_cur > m_high) begin
      m_high = m_cur;
      m_rec  = 1'b1;
    end
    tick();
    checks++; if (state_o !== 3'd3) begin errors++; $display("FAIL upd_state: got %0d want 3", state_o); end
    checks++; if (high_score !== SCORE_W'(old_high)) begin errors++; $display("FAIL early_high: got %0d want %0d", high_score, old_high); end
    tick();
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL show_state: got %0d want 4", state_o); end
    checks++; if (high_score !== SCORE_W'(m_high)) begin errors++; $display("FAIL high_e2: got %0d want %0d", high_score, m_high); end
    checks++; if (new_record !== m_rec) begin errors++; $display("FAIL rec_e2: got %0b want %0b", new_record, m_rec); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_show: got %0b want 1", busy); end
    cnt = 0;
    while (done !== 1'b1 && cnt < HOLD + 5) begin
      tick();
      cnt++;
    end
    checks++; if (cnt != HOLD) begin errors++; $display("FAIL done_latency: got %0d want %0d", cnt, HOLD); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %0b want 0", busy); end
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL idle_at_done: got %0d want 0", state_o); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_width: got %0b want 0", done); end
    checks++; if (new_record !== m_rec) begin errors++; $display("FAIL rec_hold: got %0b want %0b", new_record, m_rec); end
    checks++; if (current_score !== SCORE_W'(m_cur)) begin errors++; $display("FAIL score_hold: got %0d want %0d", current_score, m_cur); end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({state_o, current_score, high_score, new_record, busy, done} !== '0) begin
      errors++;
      $display("FAIL %s: state=%0d cur=%0d high=%0d rec=%0b busy=%0b done=%0b want all 0",
               tag, state_o, current_score, high_score, new_record, busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_initial");
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) begin
      point_inc = 1'b1;
      tick();
      point_inc = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_midplay");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    checks++; if (state_o !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_release: state=%0d busy=%0b want 0 0", state_o, busy); end
    m_high = 0;
    m_cur  = 0;
    m_rec  = 1'b0;
  endtask

  task automatic test_ignored_in_idle();
    point_inc = 1'b1;
    game_over = 1'b1;
    repeat (2) tick();
    point_inc = 1'b0;
    game_over = 1'b0;
    checks++; if (state_o !== 3'd0) begin errors++; $display("FAIL idle_ignore_state: got %0d want 0", state_o); end
    checks++; if (current_score !== SCORE_W'(m_cur)) begin errors++; $display("FAIL idle_ignore_score: got %0d want %0d", current_score, m_cur); end
  endtask

  task automatic test_first_record();
    do_round(5, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_no_record_and_tie();
    do_round(3, 1'b0, 1'b1, 1'b0);
    do_round(5, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_saturation();
    do_round(300, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear_hs();
    do_round(2, 1'b0, 1'b1, 1'b0);
    clear_hs = 1'b1;
    tick();
    clear_hs = 1'b0;
    m_high = 0;
    checks++; if (high_score !== SCORE_W'(0)) begin errors++; $display("FAIL clear_idle: got %0d want 0", high_score); end
  endtask

  task automatic test_merge();
    do_round(10, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random_rounds();
    for (int r = 0; r < 6; r++)
      do_round(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
               1'b1, 1'($urandom_range(0, 1)));
  endtask

  task automatic test_reset_in_show();
    bit saw_done;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) begin
      point_inc = 1'b1;
      tick();
      point_inc = 1'b0;
    end
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    repeat (5) tick();
    checks++; if (state_o !== 3'd4) begin errors++; $display("FAIL pre_abort_state: got %0d want 4", state_o); end
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_in_show");
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (HOLD + 5) begin
      tick();
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_done: got done pulse want none"); end
    check_all_zero("after_abort");
  endtask

  initial begin
    test_reset();
    test_ignored_in_idle();
    test_first_record();
    test_no_record_and_tie();
    test_saturation();
    test_clear_hs();
    test_merge();
    test_random_rounds();
    test_reset_in_show();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
